// File: rtl/n2tl_rls_pkg.sv
// n2tl_rls_pkg
// Shared definitions for the multi-slot TileLink Release tracker:
//   - one-hot slot-state encodings and the matching enum type
//   - default parameter values
//   - lowest-set-bit priority encoder used by the allocator and the
//     timeout reporter
//   - ASCII decode of a slot state for waveform/debug viewing
package n2tl_rls_pkg;

   localparam logic [2:0] SLOT_IDLE   = 3'h1;
   localparam logic [2:0] SLOT_ACK_WT = 3'h2;
   localparam logic [2:0] SLOT_DONE   = 3'h4;

   typedef enum logic [2:0] {
      ST_IDLE   = SLOT_IDLE,
      ST_ACK_WT = SLOT_ACK_WT,
      ST_DONE   = SLOT_DONE
   } slot_state_e;

   localparam int DEF_NUM_SLOTS      = 4;
   localparam int DEF_SRC_W          = 4;
   localparam int DEF_TMO_W          = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // Upper bound on NUM_SLOTS; encoder inputs are zero-padded to this width.
   localparam int MAX_SLOTS = 16;
   localparam int IDX_W     = 4;

   // Index of the lowest set bit; 0 when the vector is empty, so callers
   // qualify the result with a reduction-OR of the same vector.
   function automatic logic [IDX_W-1:0] lsb_index(input logic [MAX_SLOTS-1:0] vec);
      lsb_index = '0;
      for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
         if (vec[i]) lsb_index = IDX_W'(i);
      end
   endfunction

   // Six-character state name for debug displays only.
   function automatic logic [47:0] slot_state_ascii(input slot_state_e s);
      case (s)
         ST_IDLE:   slot_state_ascii = "IDLE  ";
         ST_ACK_WT: slot_state_ascii = "ACK_WT";
         ST_DONE:   slot_state_ascii = "DONE  ";
         default:   slot_state_ascii = "??????";
      endcase
   endfunction

endpackage

// File: rtl/n2tl_rls_slot.sv
// n2tl_rls_slot
// One outstanding-release slot: state machine, captured source ID and
// ACK_WT cycle counter. Matching and allocation decisions are made by the
// parent; this block only sequences its own state.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | free, may be allocated
//   ST_ACK_WT | release issued, waiting for ReleaseAck with our source
//   ST_DONE   | ack seen this cycle, returns to IDLE on the next edge
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   alloc        parent selected this slot for the incoming release
//   alloc_src    source ID to capture on allocation
//   ack_hit      a ReleaseAck matching this slot arrived this cycle
//   state        current slot state
//   state_nxt    state after the coming edge (feeds occupancy/full)
//   src          captured source ID
//   tmo_hit      timeout decision this cycle (already loses to ack_hit)
module n2tl_rls_slot
   import n2tl_rls_pkg::*;
#(
   parameter int SRC_W          = DEF_SRC_W,
   parameter int TMO_W          = DEF_TMO_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc,
   input  logic [SRC_W-1:0] alloc_src,
   input  logic             ack_hit,
   output slot_state_e      state,
   output slot_state_e      state_nxt,
   output logic [SRC_W-1:0] src,
   output logic             tmo_hit
);

   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

   logic [TMO_W-1:0] cnt;
   logic [TMO_W-1:0] cnt_nxt;
   logic [SRC_W-1:0] src_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         src   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         src   <= src_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      src_nxt   = src;
      // A matching ack in the terminal cycle takes precedence over timeout.
      tmo_hit   = TMO_EN && (state == ST_ACK_WT) && (cnt == TMO_LAST) && !ack_hit;
      case (state)
         ST_IDLE: begin
            if (alloc) begin
               state_nxt = ST_ACK_WT;
               src_nxt   = alloc_src;
               cnt_nxt   = '0;
            end
         end
         ST_ACK_WT: begin
            if (ack_hit) begin
               state_nxt = ST_DONE;
            end else if (tmo_hit) begin
               state_nxt = ST_IDLE;
            end else if (cnt != '1) begin
               cnt_nxt = cnt + TMO_W'(1);
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/n2tl_rls_tracker.sv
// n2tl_rls_tracker
// Tracks up to NUM_SLOTS outstanding TileLink Release transactions, keyed by
// source ID, between TL Logic and the OXmgr RX ReleaseAck path.
// New releases are accepted into the lowest free slot or rejected (no free
// slot, or the source is already outstanding). ReleaseAcks retire the slot
// with the same source; unmatched acks are flagged as stray. Each waiting
// slot times out after TIMEOUT_CYCLES cycles (0 disables).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   release_req/_src      new release request and its source ID
//   release_ack_rcvd/_src ReleaseAck pulse and its source ID
//   release_req_ack       request accepted (registered pulse)
//   release_req_nack      request rejected (registered pulse)
//   release_done/_src     slot retired by matching ack, with its source
//   release_timeout/_src  slot timed out, with its source
//   stray_ack             ack matched no waiting slot
//   outstanding_cnt       slots in ACK_WT or DONE after the last edge
//   full                  no IDLE slot after the last edge
module n2tl_rls_tracker
   import n2tl_rls_pkg::*;
#(
   parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
   parameter int SRC_W          = DEF_SRC_W,
   parameter int TMO_W          = DEF_TMO_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               release_req,
   input  logic [SRC_W-1:0]                   release_src,
   input  logic                               release_ack_rcvd,
   input  logic [SRC_W-1:0]                   release_ack_src,
   output logic                               release_req_ack,
   output logic                               release_req_nack,
   output logic                               release_done,
   output logic [SRC_W-1:0]                   release_done_src,
   output logic                               release_timeout,
   output logic [SRC_W-1:0]                   release_timeout_src,
   output logic                               stray_ack,
   output logic [$clog2(NUM_SLOTS+1)-1:0]     outstanding_cnt,
   output logic                               full
);

   localparam int CNT_W = $clog2(NUM_SLOTS + 1);

   slot_state_e      st       [NUM_SLOTS];
   slot_state_e      st_nxt   [NUM_SLOTS];
   logic [SRC_W-1:0] slot_src [NUM_SLOTS];

   logic [NUM_SLOTS-1:0] is_idle;
   logic [NUM_SLOTS-1:0] is_wt;
   logic [NUM_SLOTS-1:0] occ;
   logic [NUM_SLOTS-1:0] dup_vec;
   logic [NUM_SLOTS-1:0] ack_hit;
   logic [NUM_SLOTS-1:0] tmo_vec;
   logic [NUM_SLOTS-1:0] alloc_vec;
   logic [NUM_SLOTS-1:0] nxt_idle;

   logic [MAX_SLOTS-1:0] idle_pad;
   logic [MAX_SLOTS-1:0] tmo_pad;
   logic [IDX_W-1:0]     alloc_idx;
   logic [IDX_W-1:0]     tmo_idx;
   logic [SRC_W-1:0]     tmo_src_sel;
   logic                 alloc_ok;
   logic [CNT_W-1:0]     occ_cnt_nxt;

   always_comb begin
      is_idle  = '0;
      is_wt    = '0;
      occ      = '0;
      dup_vec  = '0;
      ack_hit  = '0;
      nxt_idle = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         is_idle[i]  = (st[i] == ST_IDLE);
         is_wt[i]    = (st[i] == ST_ACK_WT);
         // DONE still holds its source for one more cycle, so it blocks reuse.
         occ[i]      = (st[i] == ST_ACK_WT) || (st[i] == ST_DONE);
         dup_vec[i]  = occ[i] && (slot_src[i] == release_src);
         ack_hit[i]  = release_ack_rcvd && is_wt[i] && (slot_src[i] == release_ack_src);
         nxt_idle[i] = (st_nxt[i] == ST_IDLE);
      end
   end

   always_comb begin
      idle_pad                  = '0;
      idle_pad[NUM_SLOTS-1:0]   = is_idle;
      alloc_idx                 = lsb_index(idle_pad);
      alloc_ok                  = release_req && (|is_idle) && !(|dup_vec);
      alloc_vec                 = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         alloc_vec[i] = alloc_ok && (alloc_idx == IDX_W'(i));
      end
   end

   // Coincident timeouts cannot arise from single allocation per cycle, but
   // the lowest index is reported if they ever do.
   always_comb begin
      tmo_pad                = '0;
      tmo_pad[NUM_SLOTS-1:0] = tmo_vec;
      tmo_idx                = lsb_index(tmo_pad);
      tmo_src_sel            = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (tmo_idx == IDX_W'(i)) tmo_src_sel = slot_src[i];
      end
   end

   always_comb begin
      occ_cnt_nxt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         occ_cnt_nxt = occ_cnt_nxt + CNT_W'(!nxt_idle[i]);
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      n2tl_rls_slot #(
         .SRC_W          (SRC_W),
         .TMO_W          (TMO_W),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .alloc     (alloc_vec[g]),
         .alloc_src (release_src),
         .ack_hit   (ack_hit[g]),
         .state     (st[g]),
         .state_nxt (st_nxt[g]),
         .src       (slot_src[g]),
         .tmo_hit   (tmo_vec[g])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         release_req_ack     <= 1'b0;
         release_req_nack    <= 1'b0;
         release_done        <= 1'b0;
         release_done_src    <= '0;
         release_timeout     <= 1'b0;
         release_timeout_src <= '0;
         stray_ack           <= 1'b0;
         outstanding_cnt     <= '0;
         full                <= 1'b0;
      end else begin
         release_req_ack     <= alloc_ok;
         release_req_nack    <= release_req && !alloc_ok;
         release_done        <= |ack_hit;
         release_done_src    <= (|ack_hit) ? release_ack_src : '0;
         release_timeout     <= |tmo_vec;
         release_timeout_src <= (|tmo_vec) ? tmo_src_sel : '0;
         stray_ack           <= release_ack_rcvd && !(|ack_hit);
         outstanding_cnt     <= occ_cnt_nxt;
         full                <= !(|nxt_idle);
      end
   end

endmodule
